// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier and its result drain:
// default array geometry, drain FSM states and index-width helpers.
package systolic_pkg;

  localparam int unsigned SYS_M = 8;
  localparam int unsigned SYS_X = 4;
  localparam int unsigned SYS_Y = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2,
    FIN    = 2'd3
  } drain_state_e;

  // An index over n items needs at least one bit, even when n == 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned filter_width(input int unsigned x);
    return idx_width(x);
  endfunction

  function automatic int unsigned pixel_width(input int unsigned y);
    return idx_width(y);
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Valid/ready result stream leaving the drain: one M-bit word per beat,
// tagged with its filter/pixel indices and a last-beat flag.
interface systolic_result_drain_if
  import systolic_pkg::*;
#(
  parameter int unsigned M = SYS_M,
  parameter int unsigned X = SYS_X,
  parameter int unsigned Y = SYS_Y
);

  localparam int unsigned FW = filter_width(X);
  localparam int unsigned PW = pixel_width(Y);

  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic [FW-1:0] out_f;
  logic [PW-1:0] out_p;
  logic          out_last;

  modport master (
    output out_valid, out_data, out_f, out_p, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_f, out_p, out_last,
    output out_ready
  );

endinterface

// File: rtl/drain_index_counter.sv
// Nested pixel/filter counter for the result drain: p runs 0..Y-1, and f
// steps each time p wraps. wrap flags the final (X-1, Y-1) position.
module drain_index_counter
  import systolic_pkg::*;
#(
  parameter  int unsigned X  = SYS_X,
  parameter  int unsigned Y  = SYS_Y,
  localparam int unsigned FW = filter_width(X),
  localparam int unsigned PW = pixel_width(Y)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [FW-1:0] f,
  output logic [PW-1:0] p,
  output logic          wrap
);

  localparam logic [FW-1:0] F_MAX = FW'(X - 1);
  localparam logic [PW-1:0] P_MAX = PW'(Y - 1);

  logic p_end;
  logic f_end;

  // Explicit terminal compares so non-power-of-2 sizes wrap correctly.
  assign p_end = (p == P_MAX);
  assign f_end = (f == F_MAX);
  assign wrap  = p_end & f_end;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      f <= '0;
      p <= '0;
    end else if (clear) begin
      f <= '0;
      p <= '0;
    end else if (advance) begin
      if (p_end) begin
        p <= '0;
        f <= f_end ? '0 : f + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the flat PE result bus on start and streams it out row-major over
// valid/ready. Define DRAIN_CHECKSUM_EN to append an XOR checksum beat.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned M = SYS_M,
  parameter int unsigned X = SYS_X,
  parameter int unsigned Y = SYS_Y
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [X*Y*M-1:0]       Data,
  systolic_result_drain_if.master drn,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned FW = filter_width(X);
  localparam int unsigned PW = pixel_width(Y);

  drain_state_e state;
  drain_state_e state_next;

  // Packed [f][p] view puts word f*Y+p at the same bit offset as in Data.
  logic [X-1:0][Y-1:0][M-1:0] snap;
  logic [FW-1:0]              f;
  logic [PW-1:0]              p;
  logic                       wrap;
  logic                       capture;
  logic                       advance;
  logic [M-1:0]               word;

  assign capture = (state == IDLE) & start;
  assign advance = (state == STREAM) & drn.out_ready;
  assign word    = snap[f][p];

  drain_index_counter #(
    .X (X),
    .Y (Y)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (capture),
    .advance (advance),
    .f       (f),
    .p       (p),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: the snapshot is a plain register bank, so it is reset like any other flop.
  always_ff @(posedge clk) begin
    if (!rst)         snap <= '0;
    else if (capture) snap <= Data;
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [M-1:0] csum;

  always_ff @(posedge clk) begin
    if (!rst)         csum <= '0;
    else if (capture) csum <= '0;
    else if (advance) csum <= csum ^ word;
  end
`endif

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next    = state;
    drn.out_valid = 1'b0;
    drn.out_data  = '0;
    drn.out_f     = f;
    drn.out_p     = p;
    drn.out_last  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = STREAM;
      end

      STREAM: begin
        drn.out_valid = 1'b1;
        drn.out_data  = word;
`ifdef DRAIN_CHECKSUM_EN
        if (drn.out_ready && wrap) state_next = CSUM;
`else
        drn.out_last = wrap;
        if (drn.out_ready && wrap) state_next = FIN;
`endif
      end

      CSUM: begin
`ifdef DRAIN_CHECKSUM_EN
        drn.out_valid = 1'b1;
        drn.out_data  = csum;
        drn.out_f     = '0;
        drn.out_p     = '0;
        drn.out_last  = 1'b1;
        if (drn.out_ready) state_next = FIN;
`else
        state_next = IDLE;
`endif
      end

      FIN: begin
        done       = 1'b1;
        busy       = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side unloader for the systolic matrix multiplier. On a start pulse it snapshots the flat X·Y·M-bit result bus from the PE network. It then streams the results out one M-bit word per beat over a valid/ready handshake, tagged with filter/pixel indices and a last flag. This makes it the reader that pairs with the input-side memory loaders, which serialize flat buses into the array.

## Interface
- N/A parameters beyond:
- M, 8, result word width
- X, 4, number of filters (array rows)
- Y, 64, number of image positions (array columns)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  capture request; sampled only in IDLE
- Data  in  X*Y*M  flat result bus; word k = Data[k*M +: M], k = f*Y + p
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts the word
- out_data  out  M  current word
- out_f  out  max(1,$clog2(X))  filter index of the current word
- out_p  out  max(1,$clog2(Y))  pixel index of the current word
- out_last  out  1  the current word is the final beat of the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- FSM states:
  - IDLE: the block waits for a start request.
    - On start=1 the snapshot register takes Data, f and p are cleared, and the FSM moves to STREAM.
  - STREAM: out_valid=1 and out_data is the snapshot word at index f*Y+p.
    - On a transfer (out_valid & out_ready), p increments.
    - When p wraps from Y-1 to 0, f increments.
    - A transfer at f=X-1, p=Y-1 moves the FSM to CSUM if DRAIN_CHECKSUM_EN is defined, else to FIN.
  - CSUM: out_valid=1, out_data=checksum, out_f=0, out_p=0, out_last=1. A transfer moves the FSM to FIN.
  - FIN: done=1 for exactly one cycle, then the FSM returns to IDLE.
- Order is row-major: all Y pixels of filter 0, then filter 1, and so on. Total X·Y data beats.
- out_last=1 only on the final beat. The final beat is the checksum beat when DRAIN_CHECKSUM_EN is defined, otherwise the data beat at f=X-1, p=Y-1.
- start is ignored outside IDLE; no queuing. The snapshot isolates the output from Data changes while busy.
- Handshake rules:
  - Once out_valid rises, out_data, out_f, out_p and out_last hold stable until the transfer.
  - out_valid never drops without a transfer.
  - out_ready may be high while out_valid is low; this has no effect.
- Index counters are exact-width and wrap explicitly at Y-1 and X-1. There is no reliance on power-of-2 sizes.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_f=0, out_p=0, out_last=0, busy=0, done=0, snapshot=0, checksum=0.
- Reset mid-stream aborts the frame immediately. No done pulse follows, and there is no partial resumption.

## Timing
- start sampled high at edge t gives out_valid=1 with word 0 visible after edge t.
- With out_ready held at 1, one beat transfers per cycle with no bubbles.
  - X·Y beats occupy cycles t+1 … t+X·Y.
  - Add one more cycle for the checksum beat when enabled.
  - done is high in the cycle after the final transfer, and busy drops in the same cycle that done is high.
- Backpressure: each cycle with out_ready=0 stalls exactly one cycle. Indices and data are frozen during the stall.
- start arriving in the FIN cycle is ignored. The earliest new capture is the first IDLE cycle.

## Configuration
- DRAIN_CHECKSUM_EN defined:
  - The checksum register is cleared at capture. It XORs in each transferred data word.
  - A trailing CSUM beat sends the checksum, with out_last on that beat.
  - Frame length is X·Y+1.
- DRAIN_CHECKSUM_EN not defined: no checksum register and no CSUM state. Frame length is X·Y, and out_last is on data word X·Y-1.

## Structure
- A shared package `systolic_pkg` holds:
  - the FSM state enum (IDLE, STREAM, CSUM, FIN)
  - the index-width helper functions
  - the default M/X/Y constants used by both the multiplier top and this block
- One sub-module, `drain_index_counter`, is a nested p/f counter with a wrap flag and an advance enable. Everything else lives in the top.

## Test plan
- Reset then idle: hold rst=0 for 3 cycles, then release. All outputs read 0 and stay 0 with start=0 for 20 cycles.
- Full stream, X=4, Y=64, M=8, word k=k[7:0], out_ready=1:
  - 256 beats in order with out_f/out_p correct.
  - out_last on beat 255.
  - done pulses at cycle t+257.
  - With DRAIN_CHECKSUM_EN, beat 256 is the XOR of 0..255 mod 256, which is 0x00.
- Backpressure: toggle out_ready with a 1-of-3 pattern. Every word appears exactly once, in order, and is held stable while out_valid=1 and out_ready=0.
- Snapshot isolation: change Data to all-ones one cycle after start. The streamed words still equal the pre-start pattern.
- start while busy: pulse start at beat 10 and again in the FIN cycle. There is no restart, no second frame, and exactly one done.
- Reset mid-stream: assert rst=0 at beat 100. The next cycle shows out_valid=0 and busy=0, with no done pulse. A subsequent start streams a fresh frame from f=0, p=0.
